// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer: FSM states, seconds limits and a
// helper that folds MM:SS into total seconds.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SEC_MAX     = 59;
  localparam int SEC_PER_MIN = 60;

  // 12 bits hold 63:59 (3839 s) with headroom for a 60 s step.
  function automatic logic [11:0] to_secs(input logic [5:0] mm, input logic [5:0] ss);
    return 12'(mm) * 12'(SEC_PER_MIN) + 12'(ss);
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control and display bundle between the game FSM / display driver and the
// game timer.
interface game_timer_if #(
  parameter int TIMER_W = 11
);
  logic               start;
  logic               pause;
  logic               clear;
  logic               mode_down;
  logic [5:0]         load_min;
  logic [5:0]         load_sec;
  logic               penalty_en;
  logic [5:0]         penalty_sec;
  logic               tick;
  logic [5:0]         seconds;
  logic [5:0]         minutes;
  logic [TIMER_W-1:0] timer;
  logic               running;
  logic               expired;

  modport master (
    output start, pause, clear, mode_down, load_min, load_sec, penalty_en, penalty_sec,
    input  tick, seconds, minutes, timer, running, expired
  );

  modport slave (
    input  start, pause, clear, mode_down, load_min, load_sec, penalty_en, penalty_sec,
    output tick, seconds, minutes, timer, running, expired
  );

endinterface

// File: rtl/game_timer_tick_gen.sv
// Prescaler producing a one-cycle enable every DIV enabled clocks; holds its
// partial count while en is low so a paused period resumes where it stopped.
module game_timer_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_timer.sv
// Game clock: MM:SS up or down count with pause, penalty seconds and a sticky
// expiry flag, advanced by a prescaler clock-enable in the clk domain.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int MAX_MINUTES = 30,
  parameter int TIMER_W     = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  game_timer_if.slave bus
);
  localparam int          DIV    = CLK_FREQ / TICK_HZ;
  localparam logic [11:0] CEIL_S = 12'(MAX_MINUTES * SEC_PER_MIN);
  localparam logic [5:0]  MAX_MM = 6'(MAX_MINUTES);
  localparam logic [5:0]  MAX_SS = 6'(SEC_MAX);
  localparam logic [7:0]  MIN_S8 = 8'(SEC_PER_MIN);

  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

  state_t             state, state_nxt;
  logic               mode_q;
  logic [5:0]         mm_q, ss_q, mm_nxt, ss_nxt;
  logic [TIMER_W-1:0] timer_q;
  logic               tick_p1;
  logic               tick_int, pre_en, pre_clr;
  logic               start_ok, active, pen_ok, hit;
  logic [5:0]         pen;
  logic [11:0]        cur_s, delta;
  logic [7:0]         ss_w, d_w;

  assign start_ok = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign active   = (state == ST_RUN) || (state == ST_PAUSE);
  assign pen_ok   = bus.penalty_en && active;
  assign pre_clr  = bus.clear || start_ok;
  assign pre_en   = (state == ST_RUN) && !bus.pause;

  game_timer_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pre_en),
    .clr     (pre_clr),
    .tick    (tick_int)
  );

  // Tick and penalty merge into one delta (at most 60 s), so a single
  // carry or borrow between SS and MM is always enough.
  always_comb begin
    pen    = pen_ok ? clamp6(bus.penalty_sec, MAX_SS) : 6'd0;
    cur_s  = to_secs(mm_q, ss_q);
    delta  = 12'(pen) + 12'(tick_int);
    ss_w   = 8'(ss_q);
    d_w    = delta[7:0];
    mm_nxt = mm_q;
    ss_nxt = ss_q;
    hit    = 1'b0;
    if (!mode_q) begin
      if (cur_s + delta >= CEIL_S) begin
        mm_nxt = MAX_MM;
        ss_nxt = 6'd0;
        hit    = 1'b1;
      end else if (ss_w + d_w >= MIN_S8) begin
        ss_nxt = 6'(ss_w + d_w - MIN_S8);
        mm_nxt = mm_q + 6'd1;
      end else begin
        ss_nxt = 6'(ss_w + d_w);
      end
    end else begin
      if (cur_s <= delta) begin
        mm_nxt = 6'd0;
        ss_nxt = 6'd0;
        hit    = 1'b1;
      end else if (ss_w >= d_w) begin
        ss_nxt = 6'(ss_w - d_w);
      end else begin
        ss_nxt = 6'(ss_w + MIN_S8 - d_w);
        mm_nxt = mm_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_RUN;
        ST_RUN: begin
          if (hit)            state_nxt = ST_DONE;
          else if (bus.pause) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (hit)             state_nxt = ST_DONE;
          else if (!bus.pause) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The tick that lands on the limit is counted in timer but not pulsed,
  // since the timer is already DONE when the pulse would be visible.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      mode_q  <= 1'b0;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      timer_q <= '0;
      tick_p1 <= 1'b0;
    end else if (start_ok) begin
      mode_q  <= bus.mode_down;
      mm_q    <= bus.mode_down ? clamp6(bus.load_min, MAX_MM) : 6'd0;
      ss_q    <= bus.mode_down ? clamp6(bus.load_sec, MAX_SS) : 6'd0;
      timer_q <= '0;
      tick_p1 <= 1'b0;
    end else if (active) begin
      mm_q    <= mm_nxt;
      ss_q    <= ss_nxt;
      if (tick_int) timer_q <= sat_inc(timer_q);
      tick_p1 <= tick_int && !hit;
    end else begin
      tick_p1 <= 1'b0;
    end
  end

  assign bus.tick    = tick_p1;
  assign bus.seconds = ss_q;
  assign bus.minutes = mm_q;
  assign bus.timer   = timer_q;
  assign bus.running = (state == ST_RUN);
  assign bus.expired = (state == ST_DONE);

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: directed scenarios plus randomized traffic, all
// compared each cycle against a total-seconds reference model.
module tb_game_timer;
  localparam int CF   = 4;
  localparam int TH   = 1;
  localparam int MAXM = 2;
  localparam int TW   = 11;
  localparam int DIV  = CF / TH;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  game_timer_if #(.TIMER_W(TW)) bus ();

  game_timer #(
    .CLK_FREQ    (CF),
    .TICK_HZ     (TH),
    .MAX_MINUTES (MAXM),
    .TIMER_W     (TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time kept as total seconds plus a phase within the second.
  int m_total, m_timer, m_phase;
  bit m_active, m_paused, m_done, m_down, m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] vec(input bit t, input bit r, input bit e,
                                      input int mm, input int ss, input int tm);
    return {6'd0, t, r, e, 6'(mm), 6'(ss), 11'(tm)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {6'd0, bus.tick, bus.running, bus.expired, bus.minutes, bus.seconds, bus.timer};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return vec(m_tick, m_active && !m_paused, m_done, m_total / 60, m_total % 60, m_timer);
  endfunction

  task automatic model_update();
    int  delta, t;
    bit  counted, hit;
    if (!reset_n || bus.clear) begin
      m_active = 0; m_paused = 0; m_done = 0; m_down = 0;
      m_total = 0; m_timer = 0; m_phase = 0; m_tick = 0;
    end else if (bus.start && !m_active) begin
      m_active = 1; m_paused = 0; m_done = 0; m_down = bus.mode_down;
      m_total  = bus.mode_down ? imin(int'(bus.load_min), MAXM) * 60 + imin(int'(bus.load_sec), 59) : 0;
      m_timer  = 0; m_phase = 0; m_tick = 0;
    end else if (m_active) begin
      counted = !m_paused && !bus.pause && (m_phase == DIV - 1);
      if (!m_paused && !bus.pause) m_phase = (m_phase + 1) % DIV;
      delta = int'(counted) + (bus.penalty_en ? imin(int'(bus.penalty_sec), 59) : 0);
      hit = 0;
      if (!m_down) begin
        t = m_total + delta;
        if (t >= MAXM * 60) begin t = MAXM * 60; hit = 1; end
      end else begin
        t = m_total - delta;
        if (t <= 0) begin t = 0; hit = 1; end
      end
      m_total = t;
      if (counted && m_timer < (2 ** TW) - 1) m_timer++;
      m_tick = counted && !hit;
      if (hit) begin
        m_active = 0; m_paused = 0; m_done = 1;
      end else if (!m_paused && bus.pause) begin
        m_paused = 1;
      end else if (m_paused && !bus.pause) begin
        m_paused = 0;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model", dut_vec(), mdl_vec());
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_start(input bit down, input int lm, input int ls);
    bus.mode_down = down;
    bus.load_min  = 6'(lm);
    bus.load_sec  = 6'(ls);
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    int last_tick, n_wait;
    reset_n = 1'b0;
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.mode_down = 0;
    bus.load_min = 0; bus.load_sec = 0; bus.penalty_en = 0; bus.penalty_sec = 0;
    steps(2);
    chk("reset", dut_vec(), 32'd0);
    reset_n = 1'b1;
    step();

    // Up count: 61 ticks, pulses exactly DIV clocks apart.
    pulse_start(1'b0, 0, 0);
    last_tick = -1;
    for (int i = 1; i <= 61 * DIV; i++) begin
      step();
      if (bus.tick) begin
        if (last_tick >= 0) chk("tick_gap", 32'(i - last_tick), 32'(DIV));
        last_tick = i;
      end
    end
    chk("up_61", dut_vec(), vec(1, 1, 0, 1, 1, 61));

    // Ceiling at MAXM:00, then frozen.
    steps(59 * DIV);
    chk("ceiling", dut_vec(), vec(0, 0, 1, 2, 0, 120));
    steps(10);
    chk("ceil_hold", dut_vec(), vec(0, 0, 1, 2, 0, 120));

    // Countdown from 00:02.
    pulse_start(1'b1, 0, 2);
    chk("dn_load", dut_vec(), vec(0, 1, 0, 0, 2, 0));
    steps(DIV);
    chk("dn_t1", dut_vec(), vec(1, 1, 0, 0, 1, 1));
    steps(DIV);
    chk("dn_t2", dut_vec(), vec(0, 0, 1, 0, 0, 2));

    // Pause two clocks into a period, hold, release.
    pulse_start(1'b0, 0, 0);
    steps(2);
    bus.pause = 1'b1;
    steps(20);
    chk("pause_hold", dut_vec(), vec(0, 0, 0, 0, 0, 0));
    bus.pause = 1'b0;
    n_wait = 0;
    while (!bus.tick && n_wait < 10) begin
      step();
      n_wait++;
    end
    chk("pause_resume", 32'(n_wait), 32'd3);
    chk("pause_val", dut_vec(), vec(1, 1, 0, 0, 1, 1));

    // Penalty larger than remaining countdown saturates to 00:00.
    pulse_clear();
    pulse_start(1'b1, 0, 30);
    bus.penalty_sec = 6'd45;
    bus.penalty_en  = 1'b1;
    step();
    bus.penalty_en  = 1'b0;
    chk("pen_dn", dut_vec(), vec(0, 0, 1, 0, 0, 0));

    // Penalty coincident with a tick in up mode: 00:50 + 1 + 15 = 01:06.
    pulse_clear();
    pulse_start(1'b0, 0, 0);
    steps(50 * DIV);
    chk("pen_up_pre", dut_vec(), vec(1, 1, 0, 0, 50, 50));
    steps(DIV - 1);
    bus.penalty_sec = 6'd15;
    bus.penalty_en  = 1'b1;
    step();
    bus.penalty_en  = 1'b0;
    chk("pen_up", dut_vec(), vec(1, 1, 0, 1, 6, 51));

    // Load values above the limits are clamped.
    pulse_clear();
    pulse_start(1'b1, 40, 63);
    chk("clamp", dut_vec(), vec(0, 1, 0, 2, 59, 0));

    // Reset mid-run.
    steps(DIV + 1);
    reset_n = 1'b0;
    step();
    chk("rst_run", dut_vec(), 32'd0);
    reset_n = 1'b1;

    // Clear wins over start in the same cycle.
    pulse_start(1'b0, 0, 0);
    steps(DIV + 2);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("clr_start", dut_vec(), 32'd0);

    // Penalty ignored while idle.
    bus.penalty_sec = 6'd30;
    bus.penalty_en  = 1'b1;
    step();
    bus.penalty_en  = 1'b0;
    chk("pen_idle", dut_vec(), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      reset_n         = ($urandom_range(499) != 0);
      bus.start       = ($urandom_range(39) == 0);
      bus.clear       = ($urandom_range(149) == 0);
      if ($urandom_range(29) == 0) bus.pause = ~bus.pause;
      bus.penalty_en  = ($urandom_range(19) == 0);
      bus.penalty_sec = 6'($urandom_range(59));
      bus.mode_down   = 1'($urandom_range(1));
      bus.load_min    = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(2));
      bus.load_sec    = 6'($urandom_range(63));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
